frame_bank_scheduler: RTL and testbench
=======================================

# frame_bank_scheduler

Per-channel triple-buffer frame bank scheduler for the DDR frame store, clocked in the DDR controller clock domain. It tracks, for each of the CH_NUM writer channels (four 1/16 tiles plus the focus tile), which DDR bank the writer fills and which completed bank the display reader shows, so reader and writer never share a bank. The write and read interconnects take their bank addresses from it. It also latches the focus-view selection command and applies it only on a display frame boundary.

## Interface
- CH_NUM, 5, number of writer channels.
- STALE_CYCLES, 25'd20_000_000, clk cycles without a channel vsync before that channel is flagged stale.
- CNT_W, 25, stale counter width. Must satisfy STALE_CYCLES < 2^CNT_W.

- clk  in  1  DDR controller clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- ch_vsync  in  CH_NUM  per-channel source vsync, asynchronous to clk, active-high; rising edge = frame boundary.
- disp_vsync  in  1  display vsync, asynchronous, active-high; rising edge = display frame boundary.
- ctrl_command_in  in  4  control command; 4'b1111 = focus mode.
- value_command_in  in  4  focus source value: 1=CAM_1, 2=CAM_2, 3=CAM_FUSION, 4=HDMI.
- wr_bank  out  2*CH_NUM  bank being written, per channel; channel i at bits [2i+1:2i].
- rd_bank  out  2*CH_NUM  bank being read, per channel.
- wr_frame_start  out  CH_NUM  1-cycle pulse when a channel starts writing a new bank.
- ch_stale  out  CH_NUM  1 while the channel has had no vsync edge for STALE_CYCLES cycles.
- focus_sel  out  4  active focus source; 0 = no focus view.
- focus_update  out  1  1-cycle pulse when focus_sel changes.

## Operation
- Input sync: each vsync bit passes through a 2-FF synchronizer, then an edge register. rise = sync & ~prev.
- Per-channel state: wr (2b), rd (2b), done (2b), done_valid, armed. Banks take values 0..2 only; 3 is never output.
- Reset values: wr=0, rd=2, done=2, done_valid=0, armed=0, ch_stale=0, wr_frame_start=0, focus_sel=0, focus_update=0, pending=0.
- First channel rise after reset: armed<=1, wr_frame_start pulses, banks unchanged (writer begins on bank 0).
- Later channel rise (writer frame complete):
  - done<=wr, done_valid<=1.
  - wr<=3-wr-rd, the free third bank.
  - wr_frame_start pulses.
- Display rise: every channel with done_valid=1 gets rd<=done and done_valid<=0. Channels with done_valid=0 keep rd (the last frame repeats).
- Channel rise and display rise in the same cycle: the display update is evaluated first.
  - rd_new = done_valid ? done : rd.
  - done<=wr, done_valid<=1, wr<=3-wr-rd_new.
- Invariants: wr!=rd and done!=wr at all times. The bench checks both every cycle.
- Stale counter (per channel): cleared on every rise; otherwise increments and saturates at STALE_CYCLES. ch_stale = (cnt==STALE_CYCLES). A stale channel keeps its rd bank frozen.
- Focus command:
  - ctrl_command_in==4'b1111 and value_command_in in 1..4: pending<=value.
  - ctrl_command_in==4'b1111 and value 0 or 5..15: pending holds.
  - ctrl_command_in!=4'b1111: pending<=0.
- Focus apply: on display rise, focus_sel<=pending. focus_update pulses in that same cycle only if pending!=focus_sel.
- Reset asserted mid-frame: all state returns to reset values on the next clk edge. The first post-reset edge is treated as an arming edge.

## Timing
- Async edge to output: the first clk sampling vsync high is cycle 0. Synchronizer outputs at cycle 2; wr_bank, rd_bank, wr_frame_start, focus_sel and focus_update update at the cycle-3 edge.
- Minimum vsync high and low time: 3 clk cycles. Shorter pulses may be missed; that is legal and requires no recovery.
- All outputs are registered; no combinational path from inputs to outputs.
- wr_frame_start and focus_update are exactly 1 cycle wide.
- ctrl/value command inputs are quasi-static and sampled every cycle directly (no synchronizer). The software guarantees they are stable for ≥3 clk cycles.
- Stale flag asserts exactly STALE_CYCLES cycles after the cycle the last rise was detected.

## Test plan
- Reset, then ch0 rises ×3, no display edge -> ch0 wr sequence 0,0(arm),1,0. rd stays 2. done ends at 1. wr_frame_start pulses 3 times.
- Reset, arm ch1, ch1 rise, display rise, ch1 rise -> after display rd=0. Next wr=3-1-0=2. done=1.
- Channel rise and display rise same cycle, state wr=1, rd=2, done=0, done_valid=1 -> rd=0, done=1, wr=2, done_valid=1.
- Fast writer: 5 channel rises between display edges -> rd never equals any wr value taken. Display rise then loads the latest done.
- ctrl=4'hF with value 3, then value 0, then display rise -> focus_sel=3, focus_update pulse. Then ctrl=4'h0 and display rise -> focus_sel=0, pulse. Value 7 -> no change.
- With STALE_CYCLES=100, ch2 silent -> ch_stale[2] rises after 100 cycles. Next ch2 rise clears it at the cycle-3 edge.

Source files
------------

// File: rtl/frame_bank_scheduler.sv
// Per-channel triple-buffer DDR bank scheduler with display-frame-aligned focus selection.
// Writers and the display reader are kept on different banks; all outputs are registered.
module frame_bank_scheduler #(
    parameter int          CH_NUM       = 5,
    parameter int          CNT_W        = 25,
    parameter int unsigned STALE_CYCLES = 20_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_NUM-1:0]     ch_vsync,
    input  logic                  disp_vsync,
    input  logic [3:0]            ctrl_command_in,
    input  logic [3:0]            value_command_in,
    output logic [2*CH_NUM-1:0]   wr_bank,
    output logic [2*CH_NUM-1:0]   rd_bank,
    output logic [CH_NUM-1:0]     wr_frame_start,
    output logic [CH_NUM-1:0]     ch_stale,
    output logic [3:0]            focus_sel,
    output logic                  focus_update
);

    localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);
    localparam logic [3:0]       CMD_FOCUS = 4'b1111;

    // Two metastability stages, then the edge register pair (current, previous).
    logic [CH_NUM-1:0] ch_s1_q, ch_s2_q, ch_s3_q, ch_prev_q;
    logic              disp_s1_q, disp_s2_q, disp_s3_q, disp_prev_q;
    logic [CH_NUM-1:0] ch_rise;
    logic              disp_rise;

    logic [1:0]       wr_q    [CH_NUM];
    logic [1:0]       wr_d    [CH_NUM];
    logic [1:0]       rd_q    [CH_NUM];
    logic [1:0]       rd_d    [CH_NUM];
    logic [1:0]       done_q  [CH_NUM];
    logic [1:0]       done_d  [CH_NUM];
    logic [CNT_W-1:0] cnt_q   [CH_NUM];
    logic [CNT_W-1:0] cnt_d   [CH_NUM];
    logic [CH_NUM-1:0] done_valid_q, done_valid_d;
    logic [CH_NUM-1:0] armed_q, armed_d;
    logic [CH_NUM-1:0] start_q, start_d;
    logic [CH_NUM-1:0] stale_q, stale_d;
    logic [3:0]        pending_q, pending_d;
    logic [3:0]        focus_q, focus_d;
    logic              fupd_q, fupd_d;

    assign ch_rise   = ch_s3_q & ~ch_prev_q;
    assign disp_rise = disp_s3_q & ~disp_prev_q;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        wr_d         = wr_q;
        rd_d         = rd_q;
        done_d       = done_q;
        cnt_d        = cnt_q;
        done_valid_d = done_valid_q;
        armed_d      = armed_q;
        start_d      = '0;
        stale_d      = '0;
        pending_d    = pending_q;
        focus_d      = focus_q;
        fupd_d       = 1'b0;

        for (int i = 0; i < CH_NUM; i++) begin
            // The display swap is resolved first so a same-cycle writer sees the new reader bank.
            if (disp_rise && done_valid_q[i]) begin
                rd_d[i]         = done_q[i];
                done_valid_d[i] = 1'b0;
            end

            if (ch_rise[i]) begin
                start_d[i] = 1'b1;
                cnt_d[i]   = '0;
                if (!armed_q[i]) begin
                    armed_d[i] = 1'b1;
                end else begin
                    done_d[i]       = wr_q[i];
                    done_valid_d[i] = 1'b1;
                    wr_d[i]         = 2'd3 - wr_q[i] - rd_d[i];
                end
            end else if (cnt_q[i] != STALE_MAX) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            stale_d[i] = (cnt_d[i] == STALE_MAX);
        end

        if (ctrl_command_in != CMD_FOCUS) begin
            pending_d = 4'd0;
        end else if (value_command_in >= 4'd1 && value_command_in <= 4'd4) begin
            pending_d = value_command_in;
        end

        if (disp_rise) begin
            focus_d = pending_q;
            fupd_d  = (pending_q != focus_q);
        end
    end

    // NOTE: the per-channel arrays are tiny flop banks, not RAM, so they are reset like any register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_s1_q      <= '0;
            ch_s2_q      <= '0;
            ch_s3_q      <= '0;
            ch_prev_q    <= '0;
            disp_s1_q    <= 1'b0;
            disp_s2_q    <= 1'b0;
            disp_s3_q    <= 1'b0;
            disp_prev_q  <= 1'b0;
            for (int i = 0; i < CH_NUM; i++) begin
                wr_q[i]   <= 2'd0;
                rd_q[i]   <= 2'd2;
                done_q[i] <= 2'd2;
                cnt_q[i]  <= '0;
            end
            done_valid_q <= '0;
            armed_q      <= '0;
            start_q      <= '0;
            stale_q      <= '0;
            pending_q    <= 4'd0;
            focus_q      <= 4'd0;
            fupd_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            ch_s1_q      <= ch_vsync;
            ch_s2_q      <= ch_s1_q;
            ch_s3_q      <= ch_s2_q;
            ch_prev_q    <= ch_s3_q;
            disp_s1_q    <= disp_vsync;
            disp_s2_q    <= disp_s1_q;
            disp_s3_q    <= disp_s2_q;
            disp_prev_q  <= disp_s3_q;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            done_valid_q <= done_valid_d;
            armed_q      <= armed_d;
            start_q      <= start_d;
            stale_q      <= stale_d;
            pending_q    <= pending_d;
            focus_q      <= focus_d;
            fupd_q       <= fupd_d;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_pack
        assign wr_bank[2*g +: 2] = wr_q[g];
        assign rd_bank[2*g +: 2] = rd_q[g];
    end

    assign wr_frame_start = start_q;
    assign ch_stale       = stale_q;
    assign focus_sel      = focus_q;
    assign focus_update   = fupd_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Scoreboard bench for frame_bank_scheduler: a bank/focus model pushes expected
// frame-start and focus-update events, a negedge monitor pops and compares them.
module tb_frame_bank_scheduler;

    localparam int CH = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] ch_vsync;
    logic          disp_vsync;
    logic [3:0]    ctrl_command_in, value_command_in;
    logic [2*CH-1:0] wr_bank, rd_bank;
    logic [CH-1:0] wr_frame_start, ch_stale;
    logic [3:0]    focus_sel;
    logic          focus_update;

    frame_bank_scheduler #(.CH_NUM(CH), .CNT_W(25), .STALE_CYCLES(100)) dut (
        .clk              (clk),
        .rst              (rst),
        .ch_vsync         (ch_vsync),
        .disp_vsync       (disp_vsync),
        .ctrl_command_in  (ctrl_command_in),
        .value_command_in (value_command_in),
        .wr_bank          (wr_bank),
        .rd_bank          (rd_bank),
        .wr_frame_start   (wr_frame_start),
        .ch_stale         (ch_stale),
        .focus_sel        (focus_sel),
        .focus_update     (focus_update)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct { int ch; logic [1:0] wr; logic [1:0] rd; } start_t;
    start_t     start_q[$];
    logic [3:0] focus_q[$];

    // Reference model of the per-channel bank state and focus latch.
    logic [1:0] m_wr[CH], m_rd[CH], m_done[CH];
    bit         m_dv[CH], m_arm[CH];
    logic [3:0] m_pend, m_fsel;
    int         exp_starts, got_starts, exp_fupd, got_fupd;
    logic [CH-1:0] prev_start;
    logic          prev_fupd;

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_wr[i] = 2'd0; m_rd[i] = 2'd2; m_done[i] = 2'd2; m_dv[i] = 0; m_arm[i] = 0;
        end
        m_pend = 4'd0; m_fsel = 4'd0;
        start_q.delete(); focus_q.delete();
    endtask

    task automatic apply(input logic [CH-1:0] mask, input logic disp);
        logic [1:0] rd_new;
        start_t e;
        for (int i = 0; i < CH; i++) begin
            rd_new = (disp && m_dv[i]) ? m_done[i] : m_rd[i];
            if (disp) m_dv[i] = 0;
            if (mask[i]) begin
                if (!m_arm[i]) begin
                    m_arm[i] = 1;
                end else begin
                    m_done[i] = m_wr[i];
                    m_dv[i]   = 1;
                    m_wr[i]   = 2'd3 - m_wr[i] - rd_new;
                end
                e.ch = i; e.wr = m_wr[i]; e.rd = rd_new;
                start_q.push_back(e);
                exp_starts++;
            end
            m_rd[i] = rd_new;
        end
        if (disp) begin
            if (m_pend != m_fsel) begin
                focus_q.push_back(m_pend);
                exp_fupd++;
            end
            m_fsel = m_pend;
        end
    endtask

    task automatic pulse(input logic [CH-1:0] mask, input logic disp);
        @(negedge clk);
        ch_vsync   = ch_vsync | mask;
        disp_vsync = disp;
        apply(mask, disp);
        repeat (4) @(negedge clk);
        ch_vsync   = ch_vsync & ~mask;
        disp_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_cmd(input logic [3:0] c, input logic [3:0] v);
        @(negedge clk);
        ctrl_command_in  = c;
        value_command_in = v;
        if (c != 4'hF)                     m_pend = 4'd0;
        else if (v >= 4'd1 && v <= 4'd4)   m_pend = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ch_vsync = '0; disp_vsync = 1'b0;
        ctrl_command_in = 4'd0; value_command_in = 4'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: scoreboard pops, pulse widths and bank invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) begin
                if (wr_frame_start[i]) begin
                    start_t e;
                    got_starts++;
                    checks++;
                    if (start_q.size() == 0) begin
                        errors++;
                        $display("FAIL start_unexpected ch%0d wr=%0d rd=%0d, none expected", i, wr_bank[2*i +: 2], rd_bank[2*i +: 2]);
                    end else begin
                        e = start_q.pop_front();
                        if (e.ch !== i || wr_bank[2*i +: 2] !== e.wr || rd_bank[2*i +: 2] !== e.rd) begin
                            errors++;
                            $display("FAIL start_banks got ch%0d wr=%0d rd=%0d expected ch%0d wr=%0d rd=%0d",
                                     i, wr_bank[2*i +: 2], rd_bank[2*i +: 2], e.ch, e.wr, e.rd);
                        end
                    end
                end
            end
            if (focus_update) begin
                got_fupd++;
                checks++;
                if (focus_q.size() == 0) begin
                    errors++;
                    $display("FAIL focus_unexpected focus_sel=%0d, no update expected", focus_sel);
                end else begin
                    logic [3:0] f;
                    f = focus_q.pop_front();
                    if (focus_sel !== f) begin
                        errors++;
                        $display("FAIL focus_value got %0d expected %0d", focus_sel, f);
                    end
                end
            end
            checks++;
            if ((wr_frame_start & prev_start) !== '0 || (focus_update && prev_fupd)) begin
                errors++;
                $display("FAIL pulse_width start=%b prev=%b fupd=%b prev=%b, expected single-cycle pulses",
                         wr_frame_start, prev_start, focus_update, prev_fupd);
            end
            for (int i = 0; i < CH; i++) begin
                checks++;
                if (wr_bank[2*i +: 2] == rd_bank[2*i +: 2] || wr_bank[2*i +: 2] == 2'd3 ||
                    rd_bank[2*i +: 2] == 2'd3 || dut.done_q[i] == wr_bank[2*i +: 2]) begin
                    errors++;
                    $display("FAIL invariant ch%0d wr=%0d rd=%0d done=%0d, expected distinct banks in 0..2",
                             i, wr_bank[2*i +: 2], rd_bank[2*i +: 2], dut.done_q[i]);
                end
            end
        end
        prev_start = wr_frame_start;
        prev_fupd  = focus_update;
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        ch_vsync = '0; disp_vsync = 1'b0;
        ctrl_command_in = 4'd0; value_command_in = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_bank !== 10'h000 || rd_bank !== 10'h2AA || wr_frame_start !== '0 ||
            ch_stale !== '0 || focus_sel !== 4'd0 || focus_update !== 1'b0) begin
            errors++;
            $display("FAIL reset_values wr=%h rd=%h start=%b stale=%b fsel=%0d fupd=%b expected wr=000 rd=2aa rest 0",
                     wr_bank, rd_bank, wr_frame_start, ch_stale, focus_sel, focus_update);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Exact latency of the arming edge, then two writer completions on ch0 without display.
    task automatic test_write_sequence();
        do_reset();
        repeat (3) @(negedge clk);
        ch_vsync[0] = 1'b1;
        apply(5'b00001, 1'b0);
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (wr_frame_start[0] !== (e == 3)) begin
                errors++;
                $display("FAIL start_latency edge%0d got %b expected %b", e, wr_frame_start[0], (e == 3));
            end
        end
        repeat (2) @(negedge clk);
        ch_vsync[0] = 1'b0;
        repeat (4) @(negedge clk);
        pulse(5'b00001, 1'b0);
        checks++;
        if (wr_bank[1:0] !== 2'd1 || rd_bank[1:0] !== 2'd2) begin
            errors++;
            $display("FAIL seq_second got wr=%0d rd=%0d expected wr=1 rd=2", wr_bank[1:0], rd_bank[1:0]);
        end
        pulse(5'b00001, 1'b0);
        checks++;
        if (wr_bank[1:0] !== 2'd0 || rd_bank[1:0] !== 2'd2 || dut.done_q[0] !== 2'd1) begin
            errors++;
            $display("FAIL seq_third got wr=%0d rd=%0d done=%0d expected wr=0 rd=2 done=1",
                     wr_bank[1:0], rd_bank[1:0], dut.done_q[0]);
        end
    endtask

    task automatic test_display();
        do_reset();
        pulse(5'b00010, 1'b0);
        pulse(5'b00010, 1'b0);
        pulse(5'b00000, 1'b1);
        checks++;
        if (rd_bank[3:2] !== 2'd0 || wr_bank[3:2] !== 2'd1) begin
            errors++;
            $display("FAIL disp_swap got rd=%0d wr=%0d expected rd=0 wr=1", rd_bank[3:2], wr_bank[3:2]);
        end
        pulse(5'b00010, 1'b0);
        checks++;
        if (wr_bank[3:2] !== 2'd2 || dut.done_q[1] !== 2'd1 || rd_bank[3:2] !== 2'd0) begin
            errors++;
            $display("FAIL disp_next got wr=%0d done=%0d rd=%0d expected wr=2 done=1 rd=0",
                     wr_bank[3:2], dut.done_q[1], rd_bank[3:2]);
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        pulse(5'b01000, 1'b0);
        pulse(5'b01000, 1'b0);
        pulse(5'b01000, 1'b1);
        checks++;
        if (rd_bank[7:6] !== 2'd0 || wr_bank[7:6] !== 2'd2 || dut.done_q[3] !== 2'd1 || dut.done_valid_q[3] !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle got rd=%0d wr=%0d done=%0d dv=%b expected rd=0 wr=2 done=1 dv=1",
                     rd_bank[7:6], wr_bank[7:6], dut.done_q[3], dut.done_valid_q[3]);
        end
    endtask

    task automatic test_fast_writer();
        do_reset();
        pulse(5'b10000, 1'b0);
        for (int k = 0; k < 5; k++) pulse(5'b10000, 1'b0);
        checks++;
        if (rd_bank[9:8] !== 2'd2 || wr_bank[9:8] !== 2'd1) begin
            errors++;
            $display("FAIL fast_hold got rd=%0d wr=%0d expected rd=2 wr=1", rd_bank[9:8], wr_bank[9:8]);
        end
        pulse(5'b00000, 1'b1);
        checks++;
        if (rd_bank[9:8] !== 2'd0 || rd_bank[9:8] !== m_rd[4]) begin
            errors++;
            $display("FAIL fast_latest got rd=%0d expected 0", rd_bank[9:8]);
        end
    endtask

    task automatic test_focus();
        do_reset();
        set_cmd(4'hF, 4'd3);
        set_cmd(4'hF, 4'd0);
        pulse(5'b00000, 1'b1);
        checks++;
        if (focus_sel !== 4'd3) begin
            errors++;
            $display("FAIL focus_set got %0d expected 3", focus_sel);
        end
        set_cmd(4'h0, 4'd0);
        pulse(5'b00000, 1'b1);
        checks++;
        if (focus_sel !== 4'd0) begin
            errors++;
            $display("FAIL focus_clear got %0d expected 0", focus_sel);
        end
        set_cmd(4'hF, 4'd7);
        pulse(5'b00000, 1'b1);
        checks++;
        if (focus_sel !== 4'd0) begin
            errors++;
            $display("FAIL focus_invalid got %0d expected 0", focus_sel);
        end
        set_cmd(4'hF, 4'd4);
        repeat (3) @(negedge clk);
        checks++;
        if (focus_sel !== 4'd0) begin
            errors++;
            $display("FAIL focus_early got %0d expected 0 before display edge", focus_sel);
        end
        pulse(5'b00000, 1'b1);
        checks++;
        if (focus_sel !== 4'd4) begin
            errors++;
            $display("FAIL focus_hdmi got %0d expected 4", focus_sel);
        end
    endtask

    task automatic test_stale();
        do_reset();
        @(negedge clk);
        ch_vsync[2] = 1'b1;
        apply(5'b00100, 1'b0);
        for (int e = 0; e < 104; e++) begin
            @(posedge clk);
            #1;
            if (e == 5) ch_vsync[2] = 1'b0;
            if (e == 102 || e == 103) begin
                checks++;
                if (ch_stale[2] !== (e == 103)) begin
                    errors++;
                    $display("FAIL stale_assert edge%0d got %b expected %b", e, ch_stale[2], (e == 103));
                end
            end
        end
        checks++;
        if (ch_stale[0] !== 1'b1) begin
            errors++;
            $display("FAIL stale_silent ch0 got %b expected 1", ch_stale[0]);
        end
        @(negedge clk);
        ch_vsync[2] = 1'b1;
        apply(5'b00100, 1'b0);
        for (int e = 0; e < 4; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (ch_stale[2] !== (e < 3)) begin
                errors++;
                $display("FAIL stale_clear edge%0d got %b expected %b", e, ch_stale[2], (e < 3));
            end
        end
        repeat (2) @(negedge clk);
        ch_vsync[2] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        pulse(5'b00001, 1'b0);
        pulse(5'b00001, 1'b0);
        @(negedge clk);
        ch_vsync[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (wr_bank !== 10'h000 || rd_bank !== 10'h2AA || focus_sel !== 4'd0 || ch_stale !== '0) begin
            errors++;
            $display("FAIL midframe_reset wr=%h rd=%h fsel=%0d stale=%b expected wr=000 rd=2aa fsel=0 stale=0",
                     wr_bank, rd_bank, focus_sel, ch_stale);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        apply(5'b00001, 1'b0);
        repeat (5) @(negedge clk);
        ch_vsync[0] = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_bank[1:0] !== 2'd0 || start_q.size() != 0) begin
            errors++;
            $display("FAIL midframe_arm wr=%0d pending_starts=%0d expected wr=0 and 0", wr_bank[1:0], start_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        ch_vsync = '0; disp_vsync = 1'b0;
        ctrl_command_in = 4'd0; value_command_in = 4'd0;
        exp_starts = 0; got_starts = 0; exp_fupd = 0; got_fupd = 0;
        prev_start = '0; prev_fupd = 1'b0;
        model_reset();

        test_reset();
        test_write_sequence();
        test_display();
        test_same_cycle();
        test_fast_writer();
        test_focus();
        test_stale();
        test_reset_midframe();

        repeat (4) @(negedge clk);
        checks++;
        if (got_starts != exp_starts || got_fupd != exp_fupd || start_q.size() != 0 || focus_q.size() != 0) begin
            errors++;
            $display("FAIL event_totals starts got %0d expected %0d, focus updates got %0d expected %0d",
                     got_starts, exp_starts, got_fupd, exp_fupd);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
